// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states and control bundles.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam logic [31:0] IF_FLUSH_WORD = 32'h0000_0000;
  localparam int          REG_ZERO      = 0;

  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic if_flush;
    logic id_ex_hold;
    logic id_ex_bubble;
    logic ex_mem_hold;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FREEZE   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CTRL_FLUSH    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_LU_STALL = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  // IF/ID has no reset of its own, so reset holds the PC and flushes IF/ID.
  localparam ctrl_t CTRL_RESET    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on posedge while inc is high, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline; controls are combinational
// from state and inputs, the FSM and performance counters update on posedge.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_hold,
  output logic                  if_id_hold,
  output logic                  if_flush,
  output logic                  id_ex_hold,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_hold,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  state_t r_state;
  ctrl_t  w_ctrl;
  logic   w_lu;
  logic   w_mw;
  logic   w_rs1_hit;
  logic   w_rs2_hit;

  assign w_rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign w_lu      = ex_mem_read && (ex_rd != REG_ADDR_W'(REG_ZERO)) && (w_rs1_hit || w_rs2_hit);
  assign w_mw      = mem_req && !mem_ready;

  // The load has already moved on while in LU_STALL, so load-use is ignored there.
  always_comb begin
    w_ctrl = CTRL_NONE;
    if (reset) begin
      w_ctrl = CTRL_RESET;
    end else if (w_mw) begin
      w_ctrl = CTRL_FREEZE;
    end else if (ex_branch_taken) begin
      w_ctrl = CTRL_FLUSH;
    end else if (w_lu && (r_state != LU_STALL)) begin
      w_ctrl = CTRL_LU_STALL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN, MEM_WAIT: begin
          if (w_mw) begin
            r_state <= MEM_WAIT;
          end else if (w_lu && !ex_branch_taken) begin
            r_state <= LU_STALL;
          end else begin
            r_state <= RUN;
          end
        end
        LU_STALL: r_state <= w_mw ? MEM_WAIT : RUN;
        default:  r_state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_ctrl.pc_hold),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_ctrl.if_flush),
    .count (flush_count)
  );

  assign pc_hold      = w_ctrl.pc_hold;
  assign if_id_hold   = w_ctrl.if_id_hold;
  assign if_flush     = w_ctrl.if_flush;
  assign id_ex_hold   = w_ctrl.id_ex_hold;
  assign id_ex_bubble = w_ctrl.id_ex_bubble;
  assign ex_mem_hold  = w_ctrl.ex_mem_hold;
  assign state        = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second CNT_W=4 instance covers counter saturation.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

  logic        pc_hold, if_id_hold, if_flush, id_ex_hold, id_ex_bubble, ex_mem_hold;
  logic [1:0]  state;
  logic [15:0] stall_cycles, flush_count;

  logic        s_pc_hold, s_if_id_hold, s_if_flush, s_id_ex_hold, s_id_ex_bubble, s_ex_mem_hold;
  logic [1:0]  s_state;
  logic [3:0]  s_stall_cycles, s_flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_flush(if_flush),
    .id_ex_hold(id_ex_hold), .id_ex_bubble(id_ex_bubble), .ex_mem_hold(ex_mem_hold),
    .state(state), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(s_pc_hold), .if_id_hold(s_if_id_hold), .if_flush(s_if_flush),
    .id_ex_hold(s_id_ex_hold), .id_ex_bubble(s_id_ex_bubble), .ex_mem_hold(s_ex_mem_hold),
    .state(s_state), .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  // Control vector order: pc_hold, if_id_hold, if_flush, id_ex_hold, id_ex_bubble, ex_mem_hold
  wire [5:0] ctrl = {pc_hold, if_id_hold, if_flush, id_ex_hold, id_ex_bubble, ex_mem_hold};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start of a cycle: registered values reflect the previous cycle.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    next();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("reset_flush_cnt", 32'(flush_count), 32'd0);
    chk("reset_ctrl", 32'(ctrl), 32'b111010);
    reset = 1'b0;
    #2 chk("idle_ctrl", 32'(ctrl), 32'b000000);

    // load-use through rs2
    next();
    chk("idle_state", 32'(state), 32'd0);
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    #2 chk("lu_rs2_ctrl", 32'(ctrl), 32'b110010);
    next();
    chk("lu_rs2_state", 32'(state), 32'd1);
    chk("lu_rs2_stall_cnt", 32'(stall_cycles), 32'd1);
    #2 chk("lu_stall_no_rebubble", 32'(ctrl), 32'b000000);
    next();
    chk("lu_back_to_run", 32'(state), 32'd0);
    chk("lu_single_stall", 32'(stall_cycles), 32'd1);

    // rd = x0 never hazards
    ex_rd = 5'd0; id_rs2 = 5'd0;
    #2 chk("lu_rd_zero_ctrl", 32'(ctrl), 32'b000000);
    next();
    chk("lu_rd_zero_state", 32'(state), 32'd0);

    // matching register not actually read
    ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b0;
    #2 chk("lu_unused_rs2_ctrl", 32'(ctrl), 32'b000000);
    next();
    chk("lu_unused_rs2_state", 32'(state), 32'd0);

    // load-use through rs1
    idle_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    #2 chk("lu_rs1_ctrl", 32'(ctrl), 32'b110010);
    next();
    chk("lu_rs1_state", 32'(state), 32'd1);
    idle_inputs();
    next();
    chk("lu_rs1_stall_cnt", 32'(stall_cycles), 32'd2);

    // taken branch in RUN
    ex_branch_taken = 1'b1;
    #2 chk("br_ctrl", 32'(ctrl), 32'b011010);
    next();
    chk("br_state", 32'(state), 32'd0);
    chk("br_flush_cnt", 32'(flush_count), 32'd1);
    chk("br_stall_cnt", 32'(stall_cycles), 32'd2);

    // branch wins over a simultaneous load-use
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
    #2 chk("br_lu_ctrl", 32'(ctrl), 32'b011010);
    next();
    chk("br_lu_state", 32'(state), 32'd0);
    chk("br_lu_flush_cnt", 32'(flush_count), 32'd2);
    idle_inputs();

    // three memory-wait cycles with a branch pending, flush on release
    ex_branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2 chk($sformatf("mw_freeze_ctrl_%0d", i), 32'(ctrl), 32'b110101);
      next();
      chk($sformatf("mw_state_%0d", i), 32'(state), 32'd2);
    end
    mem_ready = 1'b1;
    #2 chk("mw_release_flush", 32'(ctrl), 32'b011010);
    next();
    chk("mw_release_state", 32'(state), 32'd0);
    chk("mw_stall_cnt", 32'(stall_cycles), 32'd5);
    chk("mw_flush_cnt", 32'(flush_count), 32'd3);
    idle_inputs();

    // reset in the middle of a memory wait
    mem_req = 1'b1; mem_ready = 1'b0;
    next();
    chk("mw2_state", 32'(state), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("midreset_state", 32'(state), 32'd0);
    chk("midreset_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("midreset_flush_cnt", 32'(flush_count), 32'd0);
    chk("midreset_ctrl", 32'(ctrl), 32'b111010);
    next();
    chk("inreset_stall_cnt", 32'(stall_cycles), 32'd0);
    reset = 1'b0;
    idle_inputs();
    #2 chk("post_reset_idle_ctrl", 32'(ctrl), 32'b000000);
    next();
    chk("post_reset_state", 32'(state), 32'd0);
    chk("post_reset_stall_cnt", 32'(stall_cycles), 32'd0);

    // 20 wait cycles: 4-bit counter saturates, 16-bit counter keeps counting
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) next();
    chk("sat_small_cnt", 32'(s_stall_cycles), 32'd15);
    chk("sat_wide_cnt", 32'(stall_cycles), 32'd20);
    chk("sat_small_state", 32'(s_state), 32'd2);
    mem_ready = 1'b1;
    next();
    chk("sat_small_release", 32'(s_state), 32'd0);
    chk("sat_small_hold", 32'(s_stall_cycles), 32'd15);
    idle_inputs();
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Detects load-use hazards in ID, taken branches/jumps resolved in EX, and data-memory wait states in MEM. Drives the hold/flush/bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers, and keeps saturating performance counters. Sits beside the datapath and is the only source of these control signals.

## Interface
- `REG_ADDR_W`, default 5: register index width.
- `CNT_W`, default 16: width of the performance counters.
- `clk` in 1: pipeline clock. FSM and counters update on posedge; pipeline registers sample controls on negedge.
- `reset` in 1: asynchronous, active-high.
- `id_rs1`, `id_rs2` in REG_ADDR_W: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1: the ID instruction actually reads rs1/rs2.
- `ex_mem_read` in 1: the EX instruction is a load.
- `ex_rd` in REG_ADDR_W: destination register of the EX instruction.
- `ex_branch_taken` in 1: a branch or jump in EX redirects the PC.
- `mem_req` in 1: the MEM stage is accessing data memory.
- `mem_ready` in 1: the data memory completes the access this cycle.
- `pc_hold` out 1: 1 = PC keeps its value.
- `if_id_hold` out 1: 1 = IF/ID holds. Drives the IF/ID `enable` input, which loads on 0.
- `if_flush` out 1: 1 = IF/ID clears to 32'h0. Takes effect only when `if_id_hold`=1.
- `id_ex_hold` out 1: ID/EX keeps its value.
- `id_ex_bubble` out 1: ID/EX loads all-zero control (NOP).
- `ex_mem_hold` out 1: EX/MEM keeps its value.
- `state` out 2: current FSM state, for debug.
- `stall_cycles` out CNT_W: count of cycles with `pc_hold`=1.
- `flush_count` out CNT_W: count of cycles with `if_flush`=1.

## Operation
- Load-use hazard (`lu`): `ex_mem_read` && `ex_rd`≠0 && ((`id_uses_rs1` && `id_rs1`==`ex_rd`) || (`id_uses_rs2` && `id_rs2`==`ex_rd`)).
- Memory wait (`mw`): `mem_req` && !`mem_ready`.
- States: RUN, LU_STALL, MEM_WAIT.
- Output priority, evaluated in every state:
  1. `mw`: `pc_hold`, `if_id_hold`, `id_ex_hold` and `ex_mem_hold` are all 1. No flush and no bubble, so the whole pipeline freezes.
  2. `ex_branch_taken`: `if_id_hold`=1, `if_flush`=1, `id_ex_bubble`=1. PC loads the target, so `pc_hold`=0.
  3. `lu`, RUN only: `pc_hold`=1, `if_id_hold`=1, `id_ex_bubble`=1.
  4. Otherwise all controls are 0.
- Transitions:
  - RUN: `mw` goes to MEM_WAIT; else `lu` && !`ex_branch_taken` goes to LU_STALL; else stays in RUN.
  - LU_STALL: `mw` goes to MEM_WAIT; else goes to RUN. Load-use is not re-evaluated here, which guarantees exactly one bubble per hazard.
  - MEM_WAIT: `mw` stays; otherwise the RUN rules apply (branch flush or load-use can occur in the release cycle).
- Flush always asserts `if_id_hold` together with `if_flush`, because IF/ID only honours the flush while holding.
- A branch taken during MEM_WAIT is held frozen and is flushed in the release cycle.
- Counters increment at posedge when their condition held in the previous cycle, saturate at all-ones and never wrap.

## Timing
- Control outputs are combinational from the state and current inputs. They are valid before the negedge of the same cycle, with zero-cycle latency.
- Reset asserted (asynchronous, any time, including mid-stall):
  - state = RUN and both counters = 0 immediately.
  - Outputs are forced to `pc_hold`=1, `if_id_hold`=1, `if_flush`=1, `id_ex_bubble`=1, all others 0. This lets the reset-less IF/ID clear itself.
  - Counters do not count during reset.
- On the first posedge after reset deasserts, the normal rules apply.
- A load-use hazard costs exactly one stall cycle. A taken branch costs a one-cycle flush. A memory wait costs N stall cycles for N cycles of !`mem_ready`.

## Structure
- `pipe_ctrl_pkg` holds:
  - State encoding: RUN=2'b00, LU_STALL=2'b01, MEM_WAIT=2'b10.
  - `IF_FLUSH_WORD` = 32'h00000000.
  - `REG_ZERO` = 0.
- Sub-module `sat_counter` (parameter W; inputs `clk`, `reset`, `inc`; output `count`), instantiated twice.

## Test plan
- Reset pulse mid-MEM_WAIT -> `state`=0, counters 0, `if_id_hold`=`if_flush`=`pc_hold`=1 while reset is high; all controls 0 in the first idle cycle after release.
- `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1 -> one cycle with `pc_hold`=`if_id_hold`=`id_ex_bubble`=1, `state`=LU_STALL for one cycle, `stall_cycles`=1.
- Same stimulus with `ex_rd`=0, or with `id_uses_rs2`=0 -> no stall.
- `ex_branch_taken`=1 in RUN -> `if_id_hold`=`if_flush`=`id_ex_bubble`=1 and `pc_hold`=0 for one cycle, `flush_count` +1.
- `mem_req`=1 with `mem_ready`=0 for 3 cycles while `ex_branch_taken`=1 -> all four holds asserted for 3 cycles, no flush; flush in the 4th (`mem_ready`=1) cycle; `stall_cycles`=3.
- `CNT_W`=4 and 20 consecutive memory-wait cycles -> `stall_cycles` saturates at 15.
